ecc_pmul_operand_bank: RTL and testbench
========================================

ECC_PMUL_OPERAND_BANK -- requirements
Module: ecc_pmul_operand_bank

Interface
REQ-001 SHALL have parameter pLAUNCH_WAIT, default 4: cycles allowed for core rdy to fall after ena.
REQ-002 SHALL have parameter pTIMEOUT_CYCLES, default 32'd50_000_000: run watchdog limit, used only with ECC_PMUL_BANK_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  crypto clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  one-cycle start request from register block.
REQ-006 SHALL have ports k_i, gx_i, gy_i  input  256 each  scalar and base point, bits [31:0] = word 0.
REQ-007 SHALL have ports k_addr, gx_addr, gy_addr  input  3 each  core word read addresses.
REQ-008 SHALL have ports k_word, gx_word, gy_word  output  32 each  registered read data.
REQ-009 SHALL have ports rx_addr, ry_addr  input  3 each; rx_wren, ry_wren  input  1 each; rx_word, ry_word  input  32 each  core result writes.
REQ-010 SHALL have port core_rdy  input  1 and core_ena  output  1  core handshake.
REQ-011 SHALL have ports rx_o, ry_o  output  256 each; result_valid, busy, err  output  1 each.

Function
REQ-012 SHALL implement states IDLE, LAUNCH, WAIT_BUSY, RUN, DONE.
REQ-013 On start_i in IDLE or DONE, SHALL snapshot k_i/gx_i/gy_i, clear write masks, rx_o, ry_o, result_valid, err, and enter LAUNCH next cycle.
REQ-014 start_i in LAUNCH, WAIT_BUSY or RUN SHALL be ignored.
REQ-015 LAUNCH SHALL assert core_ena for exactly one cycle, then enter WAIT_BUSY.
REQ-016 WAIT_BUSY SHALL enter RUN on core_rdy=0; if core_rdy stays 1 for pLAUNCH_WAIT cycles, SHALL enter DONE with err=1.
REQ-017 Read data SHALL be snapshot word [addr*32 +: 32], one-cycle latency, in every state.
REQ-018 In RUN, rx_wren=1 SHALL write rx_word into rx_o word rx_addr and set mask bit; ry likewise; simultaneous rx/ry writes SHALL both take effect.
REQ-019 Rewrites of an address SHALL overwrite data; mask bit stays set; writes outside RUN SHALL be ignored.
REQ-020 In RUN, core_rdy=1 SHALL enter DONE; a write in that same cycle SHALL still be captured; err SHALL be set if either 8-bit mask is not all ones after that capture.
REQ-021 DONE SHALL hold result_valid=1 and rx_o/ry_o stable until next accepted start_i.
REQ-022 busy SHALL be 1 in LAUNCH, WAIT_BUSY, RUN; 0 otherwise.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE and zero all outputs, snapshots, masks, counters.
REQ-024 Reset mid-run SHALL discard the operation; no result_valid after release until a new start_i.

Configuration
REQ-025 With ECC_PMUL_BANK_TIMEOUT_EN defined, a counter SHALL count RUN cycles and, on reaching pTIMEOUT_CYCLES, enter DONE with err=1 and result_valid=1.
REQ-026 Without ECC_PMUL_BANK_TIMEOUT_EN, no counter SHALL exist and RUN SHALL wait indefinitely for core_rdy.

Structure
REQ-027 State encoding, word count (8), word width (32) and address width (3) SHALL live in shared package ecc_pmul_pkg.
REQ-028 One sub-module ecc_pmul_result_collector SHALL hold rx/ry word registers and write masks.

Verification
REQ-029 start_i with k_i=1, gx/gy=P-256 G; model core writes 8+8 words then raises rdy -> result_valid=1, rx_o/ry_o match written words, err=0.
REQ-030 gx_addr=3 in any state -> gx_word = gx_i[127:96] one cycle later.
REQ-031 core writes only rx words 0..6 then rdy=1 -> result_valid=1, err=1.
REQ-032 core_rdy held 1 after core_ena -> DONE after 4 cycles, err=1, busy=0.
REQ-033 start_i during RUN and k_i changed mid-run -> ignored; k_word still returns original snapshot.
REQ-034 rst_n low in RUN -> all outputs 0 immediately; with ECC_PMUL_BANK_TIMEOUT_EN and pTIMEOUT_CYCLES=100, stalled core -> err=1 after 100 RUN cycles.

Source files
------------

// File: rtl/ecc_pmul_pkg.sv
// ============================================================================
// Module      : ecc_pmul_pkg
// Description : Shared definitions for the ECC point-multiply operand bank:
//               controller state encoding and operand word geometry.
// Contents    : state_t (controller states), NUM_WORDS, WORD_W, ADDR_W,
//               OPERAND_W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ecc_pmul_pkg;

  localparam int NUM_WORDS = 8;
  localparam int WORD_W    = 32;
  localparam int ADDR_W    = 3;
  localparam int OPERAND_W = NUM_WORDS * WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ecc_pmul_operand_bank_if.sv
// ============================================================================
// Module      : ecc_pmul_operand_bank_if
// Description : Bank <-> point-multiply core bus. Carries operand word reads,
//               result word writes and the ena/rdy launch handshake.
// Modports    : master - core side (drives addresses, writes, core_rdy)
//               slave  - bank side (drives read words, core_ena)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ecc_pmul_operand_bank_if;
  import ecc_pmul_pkg::*;

  logic [ADDR_W-1:0] k_addr;
  logic [ADDR_W-1:0] gx_addr;
  logic [ADDR_W-1:0] gy_addr;
  logic [WORD_W-1:0] k_word;
  logic [WORD_W-1:0] gx_word;
  logic [WORD_W-1:0] gy_word;
  logic [ADDR_W-1:0] rx_addr;
  logic [ADDR_W-1:0] ry_addr;
  logic              rx_wren;
  logic              ry_wren;
  logic [WORD_W-1:0] rx_word;
  logic [WORD_W-1:0] ry_word;
  logic              core_rdy;
  logic              core_ena;

  modport master (
    output k_addr, gx_addr, gy_addr,
    output rx_addr, ry_addr, rx_wren, ry_wren, rx_word, ry_word,
    output core_rdy,
    input  k_word, gx_word, gy_word,
    input  core_ena
  );

  modport slave (
    input  k_addr, gx_addr, gy_addr,
    input  rx_addr, ry_addr, rx_wren, ry_wren, rx_word, ry_word,
    input  core_rdy,
    output k_word, gx_word, gy_word,
    output core_ena
  );

endinterface

`default_nettype wire

// File: rtl/ecc_pmul_result_collector.sv
// ============================================================================
// Module      : ecc_pmul_result_collector
// Description : Holds the rx/ry result words written by the core plus one
//               written-flag per word. Reports whether both masks would be
//               complete after this cycle's writes, so a write landing in the
//               same cycle as completion still counts.
// Ports       : clk, rst_n        - clock, async active-low reset
//               clear             - zero words and masks (new operation)
//               wr_en             - writes accepted only while asserted
//               rx_/ry_ wren/addr/word - word write ports
//               rx_data, ry_data  - assembled 256-bit results
//               masks_full        - all 16 words written (incl. this cycle)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_pmul_result_collector
  import ecc_pmul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic                 rx_wren,
  input  logic [ADDR_W-1:0]    rx_addr,
  input  logic [WORD_W-1:0]    rx_word,
  input  logic                 ry_wren,
  input  logic [ADDR_W-1:0]    ry_addr,
  input  logic [WORD_W-1:0]    ry_word,
  output logic [OPERAND_W-1:0] rx_data,
  output logic [OPERAND_W-1:0] ry_data,
  output logic                 masks_full
);

  logic [NUM_WORDS-1:0] rx_mask;
  logic [NUM_WORDS-1:0] ry_mask;
  logic [NUM_WORDS-1:0] rx_mask_nx;
  logic [NUM_WORDS-1:0] ry_mask_nx;
  logic                 rx_we;
  logic                 ry_we;

  assign rx_we = wr_en && rx_wren;
  assign ry_we = wr_en && ry_wren;

  always_comb begin
    rx_mask_nx = rx_mask;
    ry_mask_nx = ry_mask;
    if (rx_we) rx_mask_nx[rx_addr] = 1'b1;
    if (ry_we) ry_mask_nx[ry_addr] = 1'b1;
  end

  assign masks_full = (&rx_mask_nx) && (&ry_mask_nx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      ry_data <= '0;
      rx_mask <= '0;
      ry_mask <= '0;
    end else if (clear) begin
      rx_data <= '0;
      ry_data <= '0;
      rx_mask <= '0;
      ry_mask <= '0;
    end else begin
      rx_mask <= rx_mask_nx;
      ry_mask <= ry_mask_nx;
      if (rx_we) rx_data[rx_addr*WORD_W +: WORD_W] <= rx_word;
      if (ry_we) ry_data[ry_addr*WORD_W +: WORD_W] <= ry_word;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ecc_pmul_operand_bank.sv
// ============================================================================
// Module      : ecc_pmul_operand_bank
// Description : Operand/result bank for an ECC point-multiply core. Snapshots
//               k, Gx, Gy on start, serves them to the core as 32-bit words,
//               launches the core, collects rx/ry result words and flags
//               incomplete results or a core that never went busy.
// Parameters  : pLAUNCH_WAIT    - cycles allowed for core_rdy to fall
//               pTIMEOUT_CYCLES - RUN watchdog limit
// Option      : ECC_PMUL_BANK_TIMEOUT_EN - enables the RUN watchdog counter;
//               when undefined RUN waits indefinitely for core_rdy.
// Ports       : clk, rst_n (async active-low), start_i, k_i/gx_i/gy_i,
//               core (bank side of the core bus), rx_o/ry_o, result_valid,
//               busy, err
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_pmul_operand_bank
  import ecc_pmul_pkg::*;
#(
  parameter int unsigned pLAUNCH_WAIT    = 4,
  parameter logic [31:0] pTIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [OPERAND_W-1:0]     k_i,
  input  logic [OPERAND_W-1:0]     gx_i,
  input  logic [OPERAND_W-1:0]     gy_i,
  ecc_pmul_operand_bank_if.slave   core,
  output logic [OPERAND_W-1:0]     rx_o,
  output logic [OPERAND_W-1:0]     ry_o,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     err
);

  localparam int WAIT_W = (pLAUNCH_WAIT > 1) ? $clog2(pLAUNCH_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(pLAUNCH_WAIT - 1);

  state_t               state;
  state_t               state_nx;
  logic                 accept;
  logic                 finish;
  logic                 finish_err;
  logic                 masks_full;
  logic                 run_expired;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [OPERAND_W-1:0] snap_k;
  logic [OPERAND_W-1:0] snap_gx;
  logic [OPERAND_W-1:0] snap_gy;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    finish     = 1'b0;
    finish_err = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          accept   = 1'b1;
          state_nx = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_nx = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!core.core_rdy) begin
          state_nx = ST_RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_nx   = ST_DONE;
        end
      end
      ST_RUN: begin
        // masks_full already includes any write landing in this cycle
        if (core.core_rdy) begin
          finish     = 1'b1;
          finish_err = !masks_full;
          state_nx   = ST_DONE;
        end else if (run_expired) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_nx   = ST_DONE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy          = (state == ST_LAUNCH) || (state == ST_WAIT_BUSY) || (state == ST_RUN);
  assign core.core_ena = (state == ST_LAUNCH);

  // Counts consecutive WAIT_BUSY cycles; only reachable there with rdy high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wait_cnt <= '0;
    else if (state == ST_WAIT_BUSY) wait_cnt <= wait_cnt + 1'b1;
    else                            wait_cnt <= '0;
  end

`ifdef ECC_PMUL_BANK_TIMEOUT_EN
  logic [31:0] run_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               run_cnt <= '0;
    else if (state == ST_RUN) run_cnt <= run_cnt + 32'd1;
    else                      run_cnt <= '0;
  end

  assign run_expired = (run_cnt == pTIMEOUT_CYCLES - 32'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^pTIMEOUT_CYCLES;
  assign run_expired    = 1'b0;
`endif

  // ---------------------------------------------------------- status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else if (accept) begin
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else if (finish) begin
      result_valid <= 1'b1;
      err          <= finish_err;
    end
  end

  // ------------------------------------------------- operand snapshot/read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_k  <= '0;
      snap_gx <= '0;
      snap_gy <= '0;
    end else if (accept) begin
      snap_k  <= k_i;
      snap_gx <= gx_i;
      snap_gy <= gy_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core.k_word  <= '0;
      core.gx_word <= '0;
      core.gy_word <= '0;
    end else begin
      core.k_word  <= snap_k[core.k_addr*WORD_W +: WORD_W];
      core.gx_word <= snap_gx[core.gx_addr*WORD_W +: WORD_W];
      core.gy_word <= snap_gy[core.gy_addr*WORD_W +: WORD_W];
    end
  end

  // ------------------------------------------------------ result collector
  ecc_pmul_result_collector u_collector (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .wr_en      (state == ST_RUN),
    .rx_wren    (core.rx_wren),
    .rx_addr    (core.rx_addr),
    .rx_word    (core.rx_word),
    .ry_wren    (core.ry_wren),
    .ry_addr    (core.ry_addr),
    .ry_word    (core.ry_word),
    .rx_data    (rx_o),
    .ry_data    (ry_o),
    .masks_full (masks_full)
  );

endmodule

`default_nettype wire

// File: tb/tb_ecc_pmul_operand_bank.sv
// ============================================================================
// Module      : tb_ecc_pmul_operand_bank
// Description : Self-checking bench for ecc_pmul_operand_bank. Plays the core
//               side of the bus and compares against a word-array model of
//               the operand snapshot and written results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ecc_pmul_operand_bank;

  localparam int          LW         = 4;
  localparam logic [31:0] TB_TIMEOUT = 32'd100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [255:0] k_i, gx_i, gy_i;
  logic [255:0] rx_o, ry_o;
  logic         result_valid, busy, err;

  always #5 clk = ~clk;

  ecc_pmul_operand_bank_if bus ();

  ecc_pmul_operand_bank #(
    .pLAUNCH_WAIT    (LW),
    .pTIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .k_i          (k_i),
    .gx_i         (gx_i),
    .gy_i         (gy_i),
    .core         (bus),
    .rx_o         (rx_o),
    .ry_o         (ry_o),
    .result_valid (result_valid),
    .busy         (busy),
    .err          (err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] k_m[8], gx_m[8], gy_m[8];
  logic [31:0] exp_rx[8], exp_ry[8];
  bit          rx_seen[8], ry_seen[8];
  logic [2:0]  ka, gxa, gya;

  task automatic check_value(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] model_rx();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = exp_rx[i];
    return r;
  endfunction

  function automatic logic [255:0] model_ry();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = exp_ry[i];
    return r;
  endfunction

  function automatic bit model_err();
    bit e = 1'b0;
    for (int i = 0; i < 8; i++) if (!rx_seen[i] || !ry_seen[i]) e = 1'b1;
    return e;
  endfunction

  task automatic clear_model_snapshot();
    for (int i = 0; i < 8; i++) begin
      k_m[i] = '0; gx_m[i] = '0; gy_m[i] = '0;
    end
  endtask

  // Random read addresses, one clock, then compare against the snapshot model
  task automatic tick_chk(input string tag);
    ka  = 3'($urandom_range(0, 7));
    gxa = 3'($urandom_range(0, 7));
    gya = 3'($urandom_range(0, 7));
    bus.k_addr  = ka;
    bus.gx_addr = gxa;
    bus.gy_addr = gya;
    tick();
    check_value({tag, "_k"},  bus.k_word,  k_m[ka]);
    check_value({tag, "_gx"}, bus.gx_word, gx_m[gxa]);
    check_value({tag, "_gy"}, bus.gy_word, gy_m[gya]);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      k_m[i]  = k_i[i*32 +: 32];
      gx_m[i] = gx_i[i*32 +: 32];
      gy_m[i] = gy_i[i*32 +: 32];
      exp_rx[i] = '0; exp_ry[i] = '0;
      rx_seen[i] = 1'b0; ry_seen[i] = 1'b0;
    end
    check_value("launch_busy", busy, 1'b1);
    check_value("launch_ena", bus.core_ena, 1'b1);
    check_value("start_clr_valid", result_valid, 1'b0);
    check_value("start_clr_err", err, 1'b0);
    check_value("start_clr_rx", rx_o, '0);
    check_value("start_clr_ry", ry_o, '0);
  endtask

  // Start, handshake into RUN, write 8 slots (+ extra rewrites), last with rdy=1
  task automatic run_op(input logic [7:0] rx_sel, input logic [7:0] ry_sel,
                        input int n_extra, input bit poke);
    int total;
    logic [255:0] rx_before, ry_before;
    do_start();
    bus.core_rdy = 1'b0;
    tick();
    check_value("ena_one_cycle", bus.core_ena, 1'b0);
    tick();
    total = 8 + n_extra;
    for (int e = 0; e < total; e++) begin
      if (e < 8) begin
        bus.rx_wren = rx_sel[e]; bus.rx_addr = 3'(e);
        bus.ry_wren = ry_sel[e]; bus.ry_addr = 3'(e);
      end else begin
        bus.rx_wren = 1'b1;                bus.rx_addr = 3'($urandom_range(0, 7));
        bus.ry_wren = 1'($urandom_range(0, 1)); bus.ry_addr = 3'($urandom_range(0, 7));
      end
      bus.rx_word = $urandom;
      bus.ry_word = $urandom;
      if (bus.rx_wren) begin exp_rx[bus.rx_addr] = bus.rx_word; rx_seen[bus.rx_addr] = 1'b1; end
      if (bus.ry_wren) begin exp_ry[bus.ry_addr] = bus.ry_word; ry_seen[bus.ry_addr] = 1'b1; end
      bus.core_rdy = (e == total - 1);
      if (poke && e == 3) begin
        start_i = 1'b1;
        k_i = rand256(); gx_i = rand256(); gy_i = rand256();
      end
      tick_chk("run_rd");
      start_i = 1'b0;
      if (e != total - 1) begin
        check_value("run_busy", busy, 1'b1);
        check_value("run_valid", result_valid, 1'b0);
      end
    end
    bus.rx_wren = 1'b0;
    bus.ry_wren = 1'b0;
    check_value("done_valid", result_valid, 1'b1);
    check_value("done_busy", busy, 1'b0);
    check_value("done_err", err, model_err());
    check_value("done_rx", rx_o, model_rx());
    check_value("done_ry", ry_o, model_ry());
    // Writes in DONE must not disturb the held result
    rx_before = model_rx();
    ry_before = model_ry();
    bus.rx_wren = 1'b1; bus.rx_addr = 3'($urandom_range(0, 7)); bus.rx_word = $urandom;
    bus.ry_wren = 1'b1; bus.ry_addr = 3'($urandom_range(0, 7)); bus.ry_word = $urandom;
    tick_chk("done_rd");
    bus.rx_wren = 1'b0;
    bus.ry_wren = 1'b0;
    check_value("done_hold_rx", rx_o, rx_before);
    check_value("done_hold_ry", ry_o, ry_before);
    check_value("done_hold_valid", result_valid, 1'b1);
  endtask

  initial begin
    int cnt;
    rst_n   = 1'b0;
    start_i = 1'b0;
    k_i = '0; gx_i = '0; gy_i = '0;
    bus.k_addr = '0; bus.gx_addr = '0; bus.gy_addr = '0;
    bus.rx_addr = '0; bus.ry_addr = '0;
    bus.rx_wren = 1'b0; bus.ry_wren = 1'b0;
    bus.rx_word = '0; bus.ry_word = '0;
    bus.core_rdy = 1'b1;
    clear_model_snapshot();
    for (int i = 0; i < 8; i++) begin exp_rx[i] = '0; exp_ry[i] = '0; end

    // Reset state
    repeat (3) tick();
    check_value("rst_rx", rx_o, '0);
    check_value("rst_ry", ry_o, '0);
    check_value("rst_flags", {result_valid, busy, err, bus.core_ena}, 4'b0);
    check_value("rst_words", {bus.k_word, bus.gx_word, bus.gy_word}, 96'b0);
    rst_n = 1'b1;
    tick();
    bus.gx_addr = 3'd3;
    tick();
    check_value("idle_gx3", bus.gx_word, 32'h0);

    // k = 1 with the P-256 base point, all 16 words written
    k_i  = 256'd1;
    gx_i = 256'h6B17D1F2_E12C4247_F8BCE6E5_63A440F2_77037D81_2DEB33A0_F4A13945_D898C296;
    gy_i = 256'h4FE342E2_FE1A7F9B_8EE7EB4A_7C0F9E16_2BCE3357_6B315ECE_CBB64068_37BF51F5;
    run_op(8'hFF, 8'hFF, 0, 1'b0);
    check_value("g_err", err, 1'b0);
    bus.gx_addr = 3'd3;
    bus.k_addr  = 3'd0;
    tick();
    check_value("g_gx3", bus.gx_word, 32'h77037D81);
    check_value("g_k0", bus.k_word, 32'h1);

    // Only rx words 0..6 written: incomplete result
    k_i = rand256(); gx_i = rand256(); gy_i = rand256();
    run_op(8'h7F, 8'h00, 0, 1'b0);
    check_value("partial_err", err, 1'b1);

    // Randomized operations, some with a start request poked mid-run
    for (int n = 0; n < 10; n++) begin
      k_i = rand256(); gx_i = rand256(); gy_i = rand256();
      run_op(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF,
             ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF,
             $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // Start during RUN plus changed operands: ignored, original snapshot kept
    k_i = rand256(); gx_i = rand256(); gy_i = rand256();
    run_op(8'hFF, 8'hFF, 2, 1'b1);

    // Core never drops rdy after ena
    k_i = rand256();
    do_start();
    cnt = 0;
    for (int c = 0; c < 20 && busy; c++) begin
      tick();
      cnt++;
    end
    check_value("launch_to_cycles", cnt, LW + 1);
    check_value("launch_to_err", err, 1'b1);
    check_value("launch_to_valid", result_valid, 1'b1);
    check_value("launch_to_busy", busy, 1'b0);

    // Asynchronous reset in the middle of RUN
    k_i = rand256(); gx_i = rand256(); gy_i = rand256();
    do_start();
    bus.core_rdy = 1'b0;
    tick();
    tick();
    bus.rx_wren = 1'b1; bus.rx_addr = 3'd2; bus.rx_word = 32'hA5A5_0001;
    bus.ry_wren = 1'b1; bus.ry_addr = 3'd5; bus.ry_word = 32'h5A5A_0002;
    tick();
    bus.rx_wren = 1'b0; bus.ry_wren = 1'b0;
    rst_n = 1'b0;
    #1;
    check_value("midrst_rx", rx_o, '0);
    check_value("midrst_ry", ry_o, '0);
    check_value("midrst_flags", {result_valid, busy, err, bus.core_ena}, 4'b0);
    check_value("midrst_words", {bus.k_word, bus.gx_word, bus.gy_word}, 96'b0);
    clear_model_snapshot();
    #2;
    rst_n = 1'b1;
    bus.core_rdy = 1'b1;
    repeat (5) tick();
    check_value("postrst_valid", result_valid, 1'b0);
    check_value("postrst_busy", busy, 1'b0);
    tick_chk("postrst_rd");

    // Stalled core in RUN
    k_i = rand256(); gx_i = rand256(); gy_i = rand256();
    do_start();
    bus.core_rdy = 1'b0;
    tick();
    tick();
`ifdef ECC_PMUL_BANK_TIMEOUT_EN
    cnt = 0;
    for (int c = 0; c < 300 && !result_valid; c++) begin
      tick();
      cnt++;
    end
    check_value("wdog_cycles", cnt, TB_TIMEOUT);
    check_value("wdog_err", err, 1'b1);
    check_value("wdog_busy", busy, 1'b0);
    bus.core_rdy = 1'b1;
`else
    repeat (300) tick();
    check_value("stall_busy", busy, 1'b1);
    check_value("stall_valid", result_valid, 1'b0);
    bus.core_rdy = 1'b1;
    tick();
    check_value("stall_end_valid", result_valid, 1'b1);
    check_value("stall_end_err", err, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
